alu_arbiter: RTL and testbench

Two-port arbiter and sequencer in front of a single shared `alu` instance (instantiated internally). It accepts operation requests from two independent requesters over valid/ready handshakes and grants the ALU round-robin. Each accepted operation is registered, executed, and returned as a registered response to the requester that issued it. Illegal opcodes are flagged rather than executed.

---
 rtl/alu_arbiter.sv | 185 ++++++++++++++++++
 tb/tb_alu_arbiter.sv | 285 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_arbiter.sv
// Two-requester round-robin arbiter sequencing operations through one shared ALU.
// Each accepted operation executes for one cycle and returns a registered response to its issuer.

module alu #(
    parameter int bits = 8
) (
    input  logic [bits-1:0] a,
    input  logic [bits-1:0] b,
    input  logic [2:0]      op,
    output logic [bits-1:0] x,
    output logic            err
);

    // Opcode decode; illegal codes produce a zero result with err set.
    always_comb begin
        x   = {bits{1'b0}};
        err = 1'b0;
        case (op)
            3'd0:    x = a + b;
            3'd1:    x = a - b;
            3'd3:    x = a & b;
            3'd4:    x = a | b;
            3'd5:    x = a ^ b;
            3'd6:    x = ~a;
            default: err = 1'b1;
        endcase
    end

endmodule

module alu_arbiter #(
    parameter int bits = 8
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            req0_valid,
    output logic            req0_ready,
    input  logic [bits-1:0] req0_a,
    input  logic [bits-1:0] req0_b,
    input  logic [2:0]      req0_op,
    output logic            rsp0_valid,
    input  logic            rsp0_ready,
    output logic [bits-1:0] rsp0_x,
    output logic            rsp0_err,
    input  logic            req1_valid,
    output logic            req1_ready,
    input  logic [bits-1:0] req1_a,
    input  logic [bits-1:0] req1_b,
    input  logic [2:0]      req1_op,
    output logic            rsp1_valid,
    input  logic            rsp1_ready,
    output logic [bits-1:0] rsp1_x,
    output logic            rsp1_err,
    output logic            busy
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] EXEC = 2'd1;
    localparam logic [1:0] RESP = 2'd2;

    logic [1:0]      state_r;
    logic            last_grant_r;
    logic            id_r;
    logic [bits-1:0] a_r;
    logic [bits-1:0] b_r;
    logic [2:0]      op_r;
    logic [bits-1:0] rsp0_x_r;
    logic [bits-1:0] rsp1_x_r;
    logic            rsp0_err_r;
    logic            rsp1_err_r;
    logic            rsp0_valid_r;
    logic            rsp1_valid_r;
    logic            busy_r;
    logic            grant0_s;
    logic            grant1_s;
    logic            rsp_done_s;
    logic [bits-1:0] alu_x_s;
    logic            alu_err_s;

    alu #(.bits(bits)) u_alu (
        .a   (a_r),
        .b   (b_r),
        .op  (op_r),
        .x   (alu_x_s),
        .err (alu_err_s)
    );

    // Round-robin grant: last_grant_r names the requester served most recently.
    // Gated by rst_n so both readies read 0 while reset is held.
    always_comb begin
        grant0_s = 1'b0;
        grant1_s = 1'b0;
        if (rst_n && (state_r == IDLE)) begin
            grant0_s = req0_valid && (!req1_valid || last_grant_r);
            grant1_s = req1_valid && (!req0_valid || !last_grant_r);
        end else begin
            grant0_s = 1'b0;
            grant1_s = 1'b0;
        end
    end

    assign rsp_done_s = id_r ? rsp1_ready : rsp0_ready;

    // Sequencer: accept, execute, then hold the response until consumed.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r      <= IDLE;
            last_grant_r <= 1'b1;
            id_r         <= 1'b0;
            a_r          <= {bits{1'b0}};
            b_r          <= {bits{1'b0}};
            op_r         <= 3'd0;
            rsp0_x_r     <= {bits{1'b0}};
            rsp1_x_r     <= {bits{1'b0}};
            rsp0_err_r   <= 1'b0;
            rsp1_err_r   <= 1'b0;
            rsp0_valid_r <= 1'b0;
            rsp1_valid_r <= 1'b0;
            busy_r       <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (grant0_s) begin
                        a_r          <= req0_a;
                        b_r          <= req0_b;
                        op_r         <= req0_op;
                        id_r         <= 1'b0;
                        last_grant_r <= 1'b0;
                        state_r      <= EXEC;
                        busy_r       <= 1'b1;
                    end else if (grant1_s) begin
                        a_r          <= req1_a;
                        b_r          <= req1_b;
                        op_r         <= req1_op;
                        id_r         <= 1'b1;
                        last_grant_r <= 1'b1;
                        state_r      <= EXEC;
                        busy_r       <= 1'b1;
                    end else begin
                        state_r <= IDLE;
                    end
                end
                EXEC: begin
                    if (id_r) begin
                        rsp1_x_r     <= alu_x_s;
                        rsp1_err_r   <= alu_err_s;
                        rsp1_valid_r <= 1'b1;
                    end else begin
                        rsp0_x_r     <= alu_x_s;
                        rsp0_err_r   <= alu_err_s;
                        rsp0_valid_r <= 1'b1;
                    end
                    state_r <= RESP;
                end
                RESP: begin
                    if (rsp_done_s) begin
                        rsp0_valid_r <= 1'b0;
                        rsp1_valid_r <= 1'b0;
                        busy_r       <= 1'b0;
                        state_r      <= IDLE;
                    end else begin
                        state_r <= RESP;
                    end
                end
                default: begin
                    rsp0_valid_r <= 1'b0;
                    rsp1_valid_r <= 1'b0;
                    busy_r       <= 1'b0;
                    state_r      <= IDLE;
                end
            endcase
        end
    end

    assign req0_ready = grant0_s;
    assign req1_ready = grant1_s;
    assign rsp0_valid = rsp0_valid_r;
    assign rsp1_valid = rsp1_valid_r;
    assign rsp0_x     = rsp0_x_r;
    assign rsp1_x     = rsp1_x_r;
    assign rsp0_err   = rsp0_err_r;
    assign rsp1_err   = rsp1_err_r;
    assign busy       = busy_r;

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed-vector bench for alu_arbiter: arbitration order, latency, illegal ops, stalls and reset.

module tb_alu_arbiter;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       req0_valid, req0_ready, rsp0_valid, rsp0_ready, rsp0_err;
    logic       req1_valid, req1_ready, rsp1_valid, rsp1_ready, rsp1_err;
    logic [7:0] req0_a, req0_b, req1_a, req1_b, rsp0_x, rsp1_x;
    logic [2:0] req0_op, req1_op;
    logic       busy;

    int tests = 0;
    int fails = 0;

    alu_arbiter #(.bits(8)) dut (
        .clk(clk), .rst_n(rst_n),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_a(req0_a), .req0_b(req0_b),
        .req0_op(req0_op), .rsp0_valid(rsp0_valid), .rsp0_ready(rsp0_ready),
        .rsp0_x(rsp0_x), .rsp0_err(rsp0_err),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_a(req1_a), .req1_b(req1_b),
        .req1_op(req1_op), .rsp1_valid(rsp1_valid), .rsp1_ready(rsp1_ready),
        .rsp1_x(rsp1_x), .rsp1_err(rsp1_err),
        .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic idle_inputs();
        req0_valid = 1'b0; req0_a = 8'h00; req0_b = 8'h00; req0_op = 3'd0; rsp0_ready = 1'b1;
        req1_valid = 1'b0; req1_a = 8'h00; req1_b = 8'h00; req1_op = 3'd0; rsp1_ready = 1'b1;
    endtask

    task automatic apply_reset();
        idle_inputs();
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        idle_inputs();
        rst_n = 1'b0;
        #1;
        tests++;
        if ({req0_ready, req1_ready, rsp0_valid, rsp1_valid, rsp0_err, rsp1_err, busy} !== 7'd0 ||
            rsp0_x !== 8'h00 || rsp1_x !== 8'h00) begin
            fails++;
            $display("FAIL reset_values: flags=%b x0=%h x1=%h, required all zero",
                     {req0_ready, req1_ready, rsp0_valid, rsp1_valid, rsp0_err, rsp1_err, busy},
                     rsp0_x, rsp1_x);
        end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_add();
        @(negedge clk);
        req0_valid = 1'b1; req0_a = 8'hF0; req0_b = 8'h20; req0_op = 3'd0;
        #1;
        tests++;
        if (req0_ready !== 1'b1) begin
            fails++; $display("FAIL add_ready: got %b want 1", req0_ready);
        end
        @(negedge clk);
        req0_valid = 1'b0;
        tests++;
        if (rsp0_valid !== 1'b0 || busy !== 1'b1) begin
            fails++; $display("FAIL add_exec: rsp0_valid=%b busy=%b want 0/1", rsp0_valid, busy);
        end
        @(negedge clk);
        tests++;
        if (rsp0_valid !== 1'b1 || rsp0_x !== 8'h10 || rsp0_err !== 1'b0 || rsp1_valid !== 1'b0) begin
            fails++;
            $display("FAIL add_resp: v0=%b x=%h err=%b v1=%b want 1/10/0/0",
                     rsp0_valid, rsp0_x, rsp0_err, rsp1_valid);
        end
        @(negedge clk);
        tests++;
        if (rsp0_valid !== 1'b0 || busy !== 1'b0) begin
            fails++; $display("FAIL add_idle: rsp0_valid=%b busy=%b want 0/0", rsp0_valid, busy);
        end
    endtask

    task automatic test_contention();
        int g = 0, r = 0, n0 = 0, n1 = 0;
        int order[4];
        apply_reset();
        req0_a = 8'h05; req0_b = 8'h07; req0_op = 3'd1;
        req1_a = 8'hAA; req1_b = 8'h0F; req1_op = 3'd5;
        for (int cyc = 0; cyc < 60 && (g < 4 || r < 4); cyc++) begin
            @(negedge clk);
            req0_valid = (n0 < 2);
            req1_valid = (n1 < 2);
            #1;
            if (rsp0_valid && rsp1_valid) begin
                tests++; fails++; $display("FAIL rr_both_rsp: both rsp_valid high");
            end
            if (rsp0_valid) begin
                tests++; r++;
                if (rsp0_x !== 8'hFE || rsp0_err !== 1'b0) begin
                    fails++; $display("FAIL rr_rsp0: x=%h err=%b want FE/0", rsp0_x, rsp0_err);
                end
            end
            if (rsp1_valid) begin
                tests++; r++;
                if (rsp1_x !== 8'hA5 || rsp1_err !== 1'b0) begin
                    fails++; $display("FAIL rr_rsp1: x=%h err=%b want A5/0", rsp1_x, rsp1_err);
                end
            end
            if (req0_ready && req1_ready) begin
                tests++; fails++; $display("FAIL rr_both_ready: both req_ready high");
            end
            if (req0_ready && g < 4) begin order[g] = 0; g++; n0++; end
            if (req1_ready && g < 4) begin order[g] = 1; g++; n1++; end
        end
        req0_valid = 1'b0; req1_valid = 1'b0;
        tests++;
        if (g != 4 || r != 4) begin
            fails++; $display("FAIL rr_count: grants=%0d responses=%0d want 4/4", g, r);
        end else begin
            if (order[0] != 0 || order[1] != 1 || order[2] != 0 || order[3] != 1) begin
                fails++;
                $display("FAIL rr_order: got %0d%0d%0d%0d want 0101",
                         order[0], order[1], order[2], order[3]);
            end
        end
    endtask

    task automatic test_illegal();
        logic [2:0] ops[2];
        ops[0] = 3'd2; ops[1] = 3'd7;
        for (int k = 0; k < 2; k++) begin
            bit seen = 1'b0;
            @(negedge clk);
            req1_valid = 1'b1; req1_a = 8'h12; req1_b = 8'h34; req1_op = ops[k];
            for (int cyc = 0; cyc < 10 && !seen; cyc++) begin
                @(negedge clk);
                if (!req1_ready) req1_valid = 1'b0;
                #1;
                if (rsp1_valid) begin
                    seen = 1'b1;
                    tests++;
                    if (rsp1_err !== 1'b1 || rsp1_x !== 8'h00 || rsp0_valid !== 1'b0) begin
                        fails++;
                        $display("FAIL illegal_op%0d: err=%b x=%h v0=%b want 1/00/0",
                                 ops[k], rsp1_err, rsp1_x, rsp0_valid);
                    end
                end
            end
            req1_valid = 1'b0;
            if (!seen) begin
                tests++; fails++; $display("FAIL illegal_timeout: no rsp1 for op %0d", ops[k]);
            end
            @(negedge clk);
        end
    endtask

    task automatic test_stall();
        @(negedge clk);
        rsp0_ready = 1'b0;
        req0_valid = 1'b1; req0_a = 8'h3C; req0_b = 8'hFF; req0_op = 3'd6;
        @(negedge clk);
        req0_valid = 1'b0;
        req1_valid = 1'b1; req1_a = 8'h0F; req1_b = 8'hF0; req1_op = 3'd5;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            #1;
            tests++;
            if (rsp0_valid !== 1'b1 || rsp0_x !== 8'hC3 || busy !== 1'b1 ||
                req0_ready !== 1'b0 || req1_ready !== 1'b0) begin
                fails++;
                $display("FAIL stall_cycle%0d: v0=%b x=%h busy=%b rdy=%b%b want 1/C3/1/00",
                         i, rsp0_valid, rsp0_x, busy, req0_ready, req1_ready);
            end
        end
        rsp0_ready = 1'b1;
        @(negedge clk);
        #1;
        tests++;
        if (rsp0_valid !== 1'b0 || busy !== 1'b0 || req1_ready !== 1'b1) begin
            fails++;
            $display("FAIL stall_release: v0=%b busy=%b rdy1=%b want 0/0/1", rsp0_valid, busy, req1_ready);
        end
        @(negedge clk);
        req1_valid = 1'b0;
        @(negedge clk);
        tests++;
        if (rsp1_valid !== 1'b1 || rsp1_x !== 8'hFF || rsp1_err !== 1'b0) begin
            fails++;
            $display("FAIL stall_next_req1: v1=%b x=%h err=%b want 1/FF/0", rsp1_valid, rsp1_x, rsp1_err);
        end
        @(negedge clk);
    endtask

    task automatic test_reset_mid();
        bit stray = 1'b0;
        apply_reset();
        req0_valid = 1'b1; req0_a = 8'h11; req0_b = 8'h22; req0_op = 3'd0;
        @(negedge clk);
        req0_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        @(negedge clk);
        req1_valid = 1'b1; req1_a = 8'hF0; req1_b = 8'h3C; req1_op = 3'd3;
        @(negedge clk);
        req1_valid = 1'b0;
        rst_n = 1'b0;
        #1;
        tests++;
        if ({req0_ready, req1_ready, rsp0_valid, rsp1_valid, rsp0_err, rsp1_err, busy} !== 7'd0 ||
            rsp0_x !== 8'h00 || rsp1_x !== 8'h00) begin
            fails++;
            $display("FAIL midreset_values: flags=%b x0=%h x1=%h want all zero",
                     {req0_ready, req1_ready, rsp0_valid, rsp1_valid, rsp0_err, rsp1_err, busy},
                     rsp0_x, rsp1_x);
        end
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            if (rsp1_valid || rsp0_valid || busy) stray = 1'b1;
        end
        tests++;
        if (stray) begin
            fails++; $display("FAIL midreset_dropped: response or busy seen after release, want none");
        end
        req0_valid = 1'b1; req1_valid = 1'b1;
        #1;
        tests++;
        if (req0_ready !== 1'b1 || req1_ready !== 1'b0) begin
            fails++;
            $display("FAIL midreset_grant: rdy0=%b rdy1=%b want 1/0", req0_ready, req1_ready);
        end
        apply_reset();
    endtask

    task automatic test_back_to_back();
        int n = 0, r = 0;
        int cyc = 0;
        int acc[2];
        @(negedge clk);
        req0_a = 8'h81; req0_b = 8'h18; req0_op = 3'd4; rsp0_ready = 1'b1;
        for (int i = 0; i < 30 && (n < 2 || r < 2); i++) begin
            if (i > 0) @(negedge clk);
            cyc++;
            req0_valid = (n < 2);
            req0_op = (n == 0) ? 3'd4 : 3'd3;
            #1;
            if (rsp0_valid) begin
                tests++;
                if (r == 0 && rsp0_x !== 8'h99) begin
                    fails++; $display("FAIL b2b_or: x=%h want 99", rsp0_x);
                end
                if (r == 1 && rsp0_x !== 8'h00) begin
                    fails++; $display("FAIL b2b_and: x=%h want 00", rsp0_x);
                end
                r++;
            end
            if (req0_ready && n < 2) begin acc[n] = cyc; n++; end
        end
        req0_valid = 1'b0;
        tests++;
        if (n != 2 || r != 2) begin
            fails++; $display("FAIL b2b_count: accepts=%0d responses=%0d want 2/2", n, r);
        end else if (acc[1] - acc[0] != 3) begin
            fails++; $display("FAIL b2b_spacing: accept gap=%0d want 3", acc[1] - acc[0]);
        end
    endtask

    initial begin
        test_reset();
        test_add();
        test_contention();
        test_illegal();
        test_stall();
        test_reset_mid();
        test_back_to_back();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
